// File: rtl/mips_pkg.sv
// Shared core types and widths.
// Register-file write port arbitration state lives here.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } wb_arb_state_t;

endpackage

// File: rtl/wb_sync_fifo.sv
// Small synchronous FIFO holding pending mul/div results.
// Caller never pushes when full nor pops when empty.
module wb_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Storage write and pointer advance; pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= r_wptr + AW'(1);
      end
      if (i_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  // Occupancy tracks push/pop; both together leave it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline (A) vs mul/div (B).
// A wins unless a queued B has lost too often; then B is forced.
module wb_port_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W       = mips_pkg::DATA_W,
  parameter int ADDR_W       = mips_pkg::REG_ADDR_W,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_dest,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_dest,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  b_count
);

  localparam int WCW = $clog2(STARVE_LIMIT) + 1;
  localparam int EW  = ADDR_W + DATA_W;

  wb_arb_state_t     r_state;
  wb_arb_state_t     w_next_state;
  logic [WCW-1:0]    r_wait;
  logic [WCW-1:0]    w_next_wait;
  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [EW-1:0]     w_head;
  logic [ADDR_W-1:0] w_sel_dest;
  logic [DATA_W-1:0] w_sel_data;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  assign w_push = b_valid & b_ready;

  wb_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_bq (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_grant_b),
    .i_data  ({b_dest, b_data}),
    .o_data  (w_head),
    .o_count (b_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign b_ready = ~w_full;
  assign a_ready = (r_state == NORMAL);

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= NORMAL;
      r_wait  <= '0;
    end else begin
      r_state <= w_next_state;
      r_wait  <= w_next_wait;
    end
  end

  // Grant selection, starvation counting and next state.
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait;
    w_grant_a    = 1'b0;
    w_grant_b    = 1'b0;
    unique case (r_state)
      NORMAL: begin
        if (a_valid) begin
          w_grant_a = 1'b1;
        end else if (!w_empty) begin
          w_grant_b = 1'b1;
        end
        if (w_empty || w_grant_b) begin
          w_next_wait = '0;
        end else begin
          w_next_wait = r_wait + WCW'(1);
          if (r_wait == WCW'(STARVE_LIMIT - 1)) begin
            w_next_state = FORCE;
          end
        end
      end
      FORCE: begin
        w_grant_b    = 1'b1;
        w_next_wait  = '0;
        w_next_state = NORMAL;
      end
      default: begin
        w_next_state = NORMAL;
        w_next_wait  = '0;
      end
    endcase
  end

  assign w_sel_dest = w_grant_a ? a_dest : w_head[EW-1:DATA_W];
  assign w_sel_data = w_grant_a ? a_data : w_head[DATA_W-1:0];

  // Registered write port; r0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_grant_a || w_grant_b) begin
      r_we    <= (w_sel_dest != '0);
      r_waddr <= w_sel_dest;
      r_wdata <= w_sel_data;
    end else begin
      r_we <= 1'b0;
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter.
// Expected values are hand-derived per scenario.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_dest;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_dest;
  logic [31:0] b_data;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [1:0]  b_count;

  int n_vec;
  int n_err;

  wb_port_arbiter #(
    .DATA_W       (32),
    .ADDR_W       (5),
    .FIFO_DEPTH   (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_valid  (a_valid),
    .a_dest   (a_dest),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_dest   (b_dest),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .b_count  (b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // starvation scenario tables
  logic [4:0] st_addr [7];
  logic       st_rdy  [7];

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    a_valid = 1'b0;
    a_dest  = '0;
    a_data  = '0;
    b_valid = 1'b0;
    b_dest  = '0;
    b_data  = '0;
    #12;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_cnt", b_count, 0);
    check("rst_ardy", a_ready, 1);
    check("rst_brdy", b_ready, 1);
    rst_n = 1'b1;
    tick();
    tick();

    // A only
    a_valid = 1'b1;
    a_dest  = 5'd5;
    a_data  = 32'hDEADBEEF;
    check("a_rdy", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("a_we", rf_we, 1);
    check("a_waddr", rf_waddr, 5);
    check("a_wdata", rf_wdata, 32'hDEADBEEF);
    tick();
    check("a_idle_we", rf_we, 0);
    check("a_hold_addr", rf_waddr, 5);

    // B only
    b_valid = 1'b1;
    b_dest  = 5'd7;
    b_data  = 32'h1234;
    check("b_rdy", b_ready, 1);
    tick();
    b_valid = 1'b0;
    check("b_n1_we", rf_we, 0);
    check("b_n1_cnt", b_count, 1);
    tick();
    check("b_n2_we", rf_we, 1);
    check("b_n2_waddr", rf_waddr, 7);
    check("b_n2_wdata", rf_wdata, 32'h1234);
    check("b_n2_cnt", b_count, 0);
    tick();

    // starvation: A held, one B queued alongside first A
    st_addr = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd6};
    st_rdy  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    a_valid = 1'b1;
    a_dest  = 5'd1;
    a_data  = 32'hA001;
    b_valid = 1'b1;
    b_dest  = 5'd9;
    b_data  = 32'h99;
    for (int i = 0; i < 7; i++) begin
      check($sformatf("st_ardy%0d", i), a_ready, st_rdy[i]);
      tick();
      b_valid = 1'b0;
      check($sformatf("st_we%0d", i), rf_we, 1);
      check($sformatf("st_addr%0d", i), rf_waddr, st_addr[i]);
      if (!st_rdy[i]) begin
        check("st_bdata", rf_wdata, 32'h99);
      end else begin
        check($sformatf("st_adata%0d", i), rf_wdata,
              32'hA000 + 32'(st_addr[i]));
        a_dest = a_dest + 5'd1;
        a_data = 32'hA000 + 32'(a_dest);
      end
    end
    a_valid = 1'b0;
    tick();
    check("st_cnt", b_count, 0);

    // full queue with A busy
    a_valid = 1'b1;
    a_dest  = 5'd20;
    a_data  = 32'hAAAA;
    b_valid = 1'b1;
    b_dest  = 5'd11;
    b_data  = 32'hB1;
    tick();
    b_dest = 5'd12;
    b_data = 32'hB2;
    tick();
    b_dest = 5'd13;
    b_data = 32'hB3;
    check("fq_cnt2", b_count, 2);
    check("fq_brdy0", b_ready, 0);
    tick();
    check("fq_brdy_e2", b_ready, 0);
    tick();
    tick();
    check("fq_ardy_force", a_ready, 0);
    check("fq_brdy_e4", b_ready, 0);
    tick();
    check("fq_b1_addr", rf_waddr, 11);
    check("fq_b1_data", rf_wdata, 32'hB1);
    check("fq_cnt1", b_count, 1);
    check("fq_brdy1", b_ready, 1);
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    check("fq_a_addr", rf_waddr, 20);
    check("fq_cnt_push", b_count, 2);
    tick();
    check("fq_b2_addr", rf_waddr, 12);
    check("fq_b2_data", rf_wdata, 32'hB2);
    tick();
    check("fq_b3_addr", rf_waddr, 13);
    check("fq_b3_data", rf_wdata, 32'hB3);
    check("fq_cnt0", b_count, 0);
    tick();

    // dest 0
    a_valid = 1'b1;
    a_dest  = 5'd0;
    a_data  = 32'hFFFF;
    check("d0_ardy", a_ready, 1);
    tick();
    a_valid = 1'b0;
    check("d0_we", rf_we, 0);
    tick();

    // reset mid-traffic with two B queued
    a_valid = 1'b1;
    a_dest  = 5'd3;
    a_data  = 32'h33;
    b_valid = 1'b1;
    b_dest  = 5'd14;
    b_data  = 32'hE;
    tick();
    b_dest = 5'd15;
    tick();
    check("pr_cnt2", b_count, 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("mr_we", rf_we, 0);
    check("mr_cnt", b_count, 0);
    check("mr_ardy", a_ready, 1);
    check("mr_brdy", b_ready, 1);
    a_valid = 1'b0;
    b_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    check("mr_post_we", rf_we, 0);
    check("mr_post_cnt", b_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
